// File: rtl/alu_mul_sequencer.sv
// Shift-add multiplier controller that borrows an external N-bit ALU for its conditional adds.
// Optional signed mode is enabled with `define MUL_SIGNED_EN (adds port signed_i).
module alu_mul_sequencer #(
  parameter int unsigned N      = 4,
  parameter logic [3:0]  OP_ADD = 4'b0010
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           start_i,
`ifdef MUL_SIGNED_EN
  input  logic           signed_i,
`endif
  input  logic [N-1:0]   multiplicando_i,
  input  logic [N-1:0]   multiplicador_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [2*N-1:0] producto_o,
  output logic [N-1:0]   alu_a_o,
  output logic [N-1:0]   alu_b_o,
  output logic           alu_c_o,
  output logic           alu_invert_o,
  output logic [3:0]     alu_operacion_o,
  input  logic [N-1:0]   alu_resultado_i,
  input  logic           alu_c_i
);

  localparam int unsigned CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ITER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   q_q, q_d;
  logic [N-1:0]   m_q, m_d;
  logic [CW-1:0]  count_q, count_d;
  logic [2*N-1:0] prod_q, prod_d;
  logic [2*N-1:0] shifted;
  logic           in_iter;

`ifdef MUL_SIGNED_EN
  logic sign_q, sign_d;
`endif

  assign in_iter = (state_q == S_ITER);

  // {A,Q} after this cycle's add-and-shift; the ALU carry becomes the new A MSB.
  assign shifted = q_q[0] ? {alu_c_i, alu_resultado_i, q_q[N-1:1]}
                          : {1'b0, a_q, q_q[N-1:1]};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    count_d = count_q;
    prod_d  = prod_q;
`ifdef MUL_SIGNED_EN
    sign_d  = sign_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
`ifdef MUL_SIGNED_EN
          m_d    = (signed_i && multiplicando_i[N-1]) ? -multiplicando_i : multiplicando_i;
          q_d    = (signed_i && multiplicador_i[N-1]) ? -multiplicador_i : multiplicador_i;
          sign_d = signed_i && (multiplicando_i[N-1] ^ multiplicador_i[N-1]);
`else
          m_d    = multiplicando_i;
          q_d    = multiplicador_i;
`endif
          a_d     = '0;
          count_d = '0;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        {a_d, q_d} = shifted;
        count_d    = count_q + CW'(1);
        if (count_q == LAST) begin
          state_d = S_DONE;
`ifdef MUL_SIGNED_EN
          prod_d  = sign_q ? -shifted : shifted;
`else
          prod_d  = shifted;
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      count_q <= '0;
      prod_q  <= '0;
`ifdef MUL_SIGNED_EN
      sign_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      count_q <= count_d;
      prod_q  <= prod_d;
`ifdef MUL_SIGNED_EN
      sign_q  <= sign_d;
`endif
    end
  end

  assign busy_o          = (state_q == S_ITER) || (state_q == S_DONE);
  assign done_o          = (state_q == S_DONE);
  assign producto_o      = prod_q;
  assign alu_a_o         = in_iter ? a_q : '0;
  assign alu_b_o         = in_iter ? m_q : '0;
  assign alu_operacion_o = in_iter ? OP_ADD : '0;
  assign alu_c_o         = 1'b0;
  assign alu_invert_o    = 1'b0;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Self-checking bench for alu_mul_sequencer with a behavioural ALU and arithmetic product model.
module tb_alu_mul_sequencer;
  localparam int unsigned N = 4;
  localparam logic [3:0] OP_ADD = 4'b0010;

  logic           clk, rst, start;
  logic [N-1:0]   mcand, mplier;
  logic           busy, done;
  logic [2*N-1:0] prod;
  logic [N-1:0]   alu_a, alu_b, alu_res;
  logic           alu_cout, alu_inv, alu_cin;
  logic [3:0]     alu_op;
  logic           sgn;
  logic [N:0]     sum;

  int checks = 0;
  int errors = 0;

  alu_mul_sequencer #(.N(N), .OP_ADD(OP_ADD)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .start_i(start),
`ifdef MUL_SIGNED_EN
    .signed_i(sgn),
`endif
    .multiplicando_i(mcand),
    .multiplicador_i(mplier),
    .busy_o(busy),
    .done_o(done),
    .producto_o(prod),
    .alu_a_o(alu_a),
    .alu_b_o(alu_b),
    .alu_c_o(alu_cout),
    .alu_invert_o(alu_inv),
    .alu_operacion_o(alu_op),
    .alu_resultado_i(alu_res),
    .alu_c_i(alu_cin)
  );

  // Behavioural ALU: only the add operation is meaningful here.
  always_comb begin
    sum = '0;
    if (alu_op == OP_ADD) sum = {1'b0, alu_a} + {1'b0, alu_b} + {{N{1'b0}}, alu_cout};
  end
  assign alu_res = alu_inv ? ~sum[N-1:0] : sum[N-1:0];
  assign alu_cin = sum[N];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [2*N-1:0] ref_prod(input logic [N-1:0] m, input logic [N-1:0] q,
                                              input logic s);
    int a, b;
    if (s) begin
      a = int'($signed(m));
      b = int'($signed(q));
    end else begin
      a = int'(m);
      b = int'(q);
    end
    return (2*N)'(a * b);
  endfunction

  task automatic run_mul(input logic [N-1:0] m, input logic [N-1:0] q, input logic s,
                         input bit hold, output int done_at, output int busy_cnt,
                         output int op_cnt, output int done_cnt, output logic [2*N-1:0] p,
                         output int restart_at, output logic [N-1:0] m2,
                         output logic [N-1:0] q2);
    done_at = -1; busy_cnt = 0; op_cnt = 0; done_cnt = 0; restart_at = -1;
    p = 'x; m2 = '0; q2 = '0;
    @(negedge clk);
    start = 1'b1; mcand = m; mplier = q; sgn = s;
    for (int k = 1; k <= int'(N) + 3; k++) begin
      @(negedge clk);
      if (done_at > 0 && busy && restart_at < 0) restart_at = k;
      else if (restart_at < 0) begin
        busy_cnt += int'(busy);
        op_cnt   += int'(alu_op == OP_ADD);
        if (done) begin
          done_cnt++;
          if (done_at < 0) begin done_at = k; p = prod; end
        end
      end
      if (hold) begin
        start = 1'b1; mcand = N'($urandom); mplier = N'($urandom);
        if (restart_at < 0) begin m2 = mcand; q2 = mplier; end
      end else start = 1'b0;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; mcand = '0; mplier = '0; sgn = 1'b0;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (prod !== '0) begin errors++; $display("FAIL reset_prod got %h want 0", prod); end
    checks++; if ({alu_a, alu_b, alu_op} !== '0) begin
      errors++; $display("FAIL reset_alu got a=%h b=%h op=%h want 0", alu_a, alu_b, alu_op); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [N-1:0] ms[4] = '{4'd3, 4'd15, 4'd0, 4'd9};
    logic [N-1:0] qs[4] = '{4'd5, 4'd15, 4'd9, 4'd0};
    logic [2*N-1:0] exp[4] = '{8'd15, 8'd225, 8'd0, 8'd0};
    int da, bc, oc, dc, ra; logic [2*N-1:0] p; logic [N-1:0] m2, q2;
    for (int i = 0; i < 4; i++) begin
      run_mul(ms[i], qs[i], 1'b0, 1'b0, da, bc, oc, dc, p, ra, m2, q2);
      checks++; if (p !== exp[i]) begin errors++; $display("FAIL dir_prod[%0d] got %0d want %0d", i, p, exp[i]); end
      checks++; if (da != int'(N) + 1) begin errors++; $display("FAIL dir_done_at[%0d] got %0d want %0d", i, da, N + 1); end
      checks++; if (bc != int'(N) + 1) begin errors++; $display("FAIL dir_busy_cycles[%0d] got %0d want %0d", i, bc, N + 1); end
      checks++; if (oc != int'(N)) begin errors++; $display("FAIL dir_op_cycles[%0d] got %0d want %0d", i, oc, N); end
      checks++; if (dc != 1) begin errors++; $display("FAIL dir_done_pulses[%0d] got %0d want 1", i, dc); end
    end
    // Product held and ALU quiet while idle.
    repeat (3) @(negedge clk);
    checks++; if (prod !== 8'd0 || busy !== 1'b0) begin errors++; $display("FAIL idle_hold got prod=%0d busy=%b want 0/0", prod, busy); end
    checks++; if ({alu_a, alu_b, alu_op} !== '0) begin
      errors++; $display("FAIL idle_alu got a=%h b=%h op=%h want 0", alu_a, alu_b, alu_op); end
  endtask

  task automatic test_random();
    int da, bc, oc, dc, ra; logic [2*N-1:0] p, e; logic [N-1:0] m, q, m2, q2; logic s;
    for (int i = 0; i < 24; i++) begin
      m = N'($urandom); q = N'($urandom);
`ifdef MUL_SIGNED_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      run_mul(m, q, s, 1'b0, da, bc, oc, dc, p, ra, m2, q2);
      e = ref_prod(m, q, s);
      checks++; if (p !== e || da != int'(N) + 1) begin
        errors++; $display("FAIL rand_prod m=%h q=%h s=%b got %h@%0d want %h@%0d", m, q, s, p, da, e, N + 1); end
      repeat (3) @(negedge clk);
      checks++; if (prod !== e) begin errors++; $display("FAIL rand_hold got %h want %h", prod, e); end
    end
  endtask

  task automatic test_back_to_back();
    int da, bc, oc, dc, ra, done2; logic [2*N-1:0] p, p2; logic [N-1:0] m2, q2;
    run_mul(4'd3, 4'd5, 1'b0, 1'b1, da, bc, oc, dc, p, ra, m2, q2);
    checks++; if (p !== 8'd15) begin errors++; $display("FAIL b2b_first got %0d want 15", p); end
    checks++; if (ra != int'(N) + 3) begin errors++; $display("FAIL b2b_restart got %0d want %0d", ra, N + 3); end
    done2 = -1; p2 = 'x;
    for (int k = 0; k < int'(N) + 4 && done2 < 0; k++) begin
      @(negedge clk);
      if (done) begin done2 = k; p2 = prod; end
    end
    checks++; if (done2 < 0 || p2 !== ref_prod(m2, q2, 1'b0)) begin
      errors++; $display("FAIL b2b_second m=%h q=%h got %h want %h", m2, q2, p2, ref_prod(m2, q2, 1'b0)); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_midop();
    int dc;
    @(negedge clk); start = 1'b1; mcand = 4'd7; mplier = 4'd11; sgn = 1'b0;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midop_busy got %b want 1", busy); end
    #2 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL async_reset got busy=%b done=%b want 0/0", busy, done); end
    checks++; if (prod !== '0 || alu_op !== '0 || alu_a !== '0) begin
      errors++; $display("FAIL async_reset_clear got prod=%h op=%h a=%h want 0", prod, alu_op, alu_a); end
    @(negedge clk); rst = 1'b0;
    dc = 0;
    for (int k = 0; k < int'(N) + 3; k++) begin
      @(negedge clk);
      dc += int'(done || busy);
    end
    checks++; if (dc != 0) begin errors++; $display("FAIL midop_no_done got %0d active cycles want 0", dc); end
  endtask

`ifdef MUL_SIGNED_EN
  task automatic test_signed();
    logic [N-1:0] ms[3] = '{4'hD, 4'h8, 4'hD};
    logic [N-1:0] qs[3] = '{4'h5, 4'h8, 4'h5};
    logic ss[3] = '{1'b1, 1'b1, 1'b0};
    logic [2*N-1:0] exp[3] = '{8'hF1, 8'd64, 8'd65};
    int da, bc, oc, dc, ra; logic [2*N-1:0] p; logic [N-1:0] m2, q2;
    for (int i = 0; i < 3; i++) begin
      run_mul(ms[i], qs[i], ss[i], 1'b0, da, bc, oc, dc, p, ra, m2, q2);
      checks++; if (p !== exp[i] || da != int'(N) + 1) begin
        errors++; $display("FAIL signed[%0d] got %h@%0d want %h@%0d", i, p, da, exp[i], N + 1); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_midop();
`ifdef MUL_SIGNED_EN
    test_signed();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end
endmodule
